// File: rtl/remote_bus_arbiter_pkg.sv
// Shared types and constants for the remote bus arbiter and its helpers.
package remote_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int ARB_WORD_W = 16;

    // Returned to the completing core when the device never answered.
    localparam logic [ARB_WORD_W-1:0] ARB_TIMEOUT_READ_VAL = 16'hFFFF;

endpackage

// File: rtl/remote_bus_arbiter_rr_picker.sv
// Combinational round-robin select: first set request at or above rr_ptr,
// scanning upward and wrapping; usable for any shared resource.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    always_comb begin
        logic [IDX_W-1:0] w_pos;
        found = 1'b0;
        idx   = '0;
        w_pos = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_pos = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!found && req[w_pos]) begin
                found = 1'b1;
                idx   = w_pos;
            end
        end
    end

endmodule

// File: rtl/remote_bus_arbiter.sv
// Round-robin arbiter sharing one off-core device bus between NUM_CORES cores,
// with per-core stall (ready) generation and a watchdog for dead devices.
module remote_bus_arbiter
    import remote_arb_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [ARB_WORD_W*NUM_CORES-1:0]   core_addr,
    input  logic [NUM_CORES-1:0]              core_wren,
    input  logic [NUM_CORES-1:0]              core_rden,
    input  logic [ARB_WORD_W*NUM_CORES-1:0]   core_write_val,
    output logic [NUM_CORES-1:0]              core_ready,
    output logic [ARB_WORD_W-1:0]             core_read_val,
    output logic [ARB_WORD_W-1:0]             bus_addr,
    output logic                              bus_wren,
    output logic                              bus_rden,
    output logic [ARB_WORD_W-1:0]             bus_write_val,
    input  logic                              bus_ready,
    input  logic [ARB_WORD_W-1:0]             bus_read_val,
    output logic                              timeout_flag,
    output logic [$clog2(NUM_CORES)-1:0]      timeout_core
);

    localparam int IDX_W = $clog2(NUM_CORES);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CORES - 1);

    arb_state_t       r_state,        w_state_nxt;
    logic [IDX_W-1:0] r_rr_ptr,       w_rr_ptr_nxt;
    logic [IDX_W-1:0] r_grant_idx,    w_grant_idx_nxt;
    logic [IDX_W-1:0] r_timeout_core, w_timeout_core_nxt;
    logic [WD_W-1:0]  r_wd_cnt,       w_wd_cnt_nxt;
    logic             r_force_l,      w_force_l_nxt;
    logic             r_timeout_flag, w_timeout_flag_nxt;

    logic [NUM_CORES-1:0] w_req;
    logic                 w_found;
    logic [IDX_W-1:0]     w_pick_idx;
    logic                 w_in_grant;
    logic                 w_gnt_req;
    logic                 w_done_ok;
    logic                 w_done_force;
    logic [IDX_W-1:0]     w_idx_inc;

    assign w_req = core_wren | core_rden;

    rr_picker #(
        .NUM_REQ (NUM_CORES),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req    (w_req),
        .rr_ptr (r_rr_ptr),
        .found  (w_found),
        .idx    (w_pick_idx)
    );

    assign w_in_grant   = (r_state == ARB_GRANT);
    assign w_gnt_req    = w_req[r_grant_idx];
    // A device ack in the watchdog's last cycle wins over the forced completion.
    assign w_done_ok    = w_in_grant & bus_ready;
    assign w_done_force = w_in_grant & ~bus_ready & (r_wd_cnt == WD_LAST);
    assign w_idx_inc    = (r_grant_idx == IDX_LAST) ? '0 : r_grant_idx + 1'b1;

    always_comb begin
        w_state_nxt        = r_state;
        w_rr_ptr_nxt       = r_rr_ptr;
        w_grant_idx_nxt    = r_grant_idx;
        w_timeout_core_nxt = r_timeout_core;
        w_wd_cnt_nxt       = r_wd_cnt;
        w_force_l_nxt      = 1'b0;
        w_timeout_flag_nxt = r_timeout_flag;
        case (r_state)
            ARB_IDLE: begin
                if (w_found) begin
                    w_state_nxt     = ARB_GRANT;
                    w_grant_idx_nxt = w_pick_idx;
                    w_wd_cnt_nxt    = '0;
                end
            end
            ARB_GRANT: begin
                if (w_done_ok) begin
                    w_state_nxt  = ARB_IDLE;
                    w_rr_ptr_nxt = w_idx_inc;
                end else if (w_done_force) begin
                    w_state_nxt        = ARB_IDLE;
                    w_rr_ptr_nxt       = w_idx_inc;
                    w_timeout_flag_nxt = 1'b1;
                    w_timeout_core_nxt = r_grant_idx;
                    w_force_l_nxt      = 1'b1;
                end else if (!w_gnt_req) begin
                    w_state_nxt = ARB_IDLE;
                end else begin
                    w_wd_cnt_nxt = r_wd_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        core_ready = '0;
        if (w_done_ok || w_done_force) begin
            core_ready[r_grant_idx] = 1'b1;
        end
        bus_addr      = core_addr[ARB_WORD_W*r_grant_idx +: ARB_WORD_W];
        bus_write_val = core_write_val[ARB_WORD_W*r_grant_idx +: ARB_WORD_W];
        bus_wren      = w_in_grant & core_wren[r_grant_idx];
        bus_rden      = w_in_grant & core_rden[r_grant_idx];
        core_read_val = r_force_l ? ARB_TIMEOUT_READ_VAL : bus_read_val;
    end

    assign timeout_flag = r_timeout_flag;
    assign timeout_core = r_timeout_core;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ARB_IDLE;
            r_rr_ptr       <= '0;
            r_grant_idx    <= '0;
            r_timeout_core <= '0;
            r_wd_cnt       <= '0;
            r_force_l      <= 1'b0;
            r_timeout_flag <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_rr_ptr       <= w_rr_ptr_nxt;
            r_grant_idx    <= w_grant_idx_nxt;
            r_timeout_core <= w_timeout_core_nxt;
            r_wd_cnt       <= w_wd_cnt_nxt;
            r_force_l      <= w_force_l_nxt;
            r_timeout_flag <= w_timeout_flag_nxt;
        end
    end

endmodule

// File: tb/tb_remote_bus_arbiter.sv
// Self-checking bench for remote_bus_arbiter: vector table, directed corner
// sequences and random traffic against a transaction-level reference model.
module tb_remote_bus_arbiter;

    localparam int N   = 4;
    localparam int TMO = 8;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [16*N-1:0] core_addr = '0;
    logic [N-1:0]    core_wren = '0;
    logic [N-1:0]    core_rden = '0;
    logic [16*N-1:0] core_write_val = '0;
    logic [N-1:0]    core_ready;
    logic [15:0]     core_read_val;
    logic [15:0]     bus_addr;
    logic            bus_wren;
    logic            bus_rden;
    logic [15:0]     bus_write_val;
    logic            bus_ready = 1'b0;
    logic [15:0]     bus_read_val = '0;
    logic            timeout_flag;
    logic [1:0]      timeout_core;

    remote_bus_arbiter #(
        .NUM_CORES (N),
        .TIMEOUT   (TMO)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .core_addr      (core_addr),
        .core_wren      (core_wren),
        .core_rden      (core_rden),
        .core_write_val (core_write_val),
        .core_ready     (core_ready),
        .core_read_val  (core_read_val),
        .bus_addr       (bus_addr),
        .bus_wren       (bus_wren),
        .bus_rden       (bus_rden),
        .bus_write_val  (bus_write_val),
        .bus_ready      (bus_ready),
        .bus_read_val   (bus_read_val),
        .timeout_flag   (timeout_flag),
        .timeout_core   (timeout_core)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the bus, how long it has held it, who last finished.
    int       m_owner;
    int       m_age;
    int       m_last;
    bit       m_flag;
    int       m_tcore;
    bit       m_force;
    logic [N-1:0] m_rdy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_age   = 0;
        m_last  = N - 1;
        m_flag  = 1'b0;
        m_tcore = 0;
        m_force = 1'b0;
        m_rdy   = '0;
    endtask

    task automatic set_core(input int c, input logic w, input logic r,
                            input logic [15:0] a, input logic [15:0] d);
        core_wren[c] = w;
        core_rden[c] = r;
        core_addr[16*c +: 16] = a;
        core_write_val[16*c +: 16] = d;
    endtask

    // Check the current cycle at the falling edge, advance the model, then
    // return 1 time unit after the next rising edge.
    task automatic tick();
        logic [N-1:0] req;
        logic [N-1:0] erdy;
        bit done;
        bit tmo;
        @(negedge clk);
        if (!reset_n) model_reset();
        req  = core_wren | core_rden;
        erdy = '0;
        done = 1'b0;
        tmo  = 1'b0;
        if (reset_n && m_owner >= 0) begin
            if (bus_ready) done = 1'b1;
            else if (m_age == TMO - 1) tmo = 1'b1;
            if (done || tmo) erdy[m_owner] = 1'b1;
        end
        chk("ready", core_ready, erdy);
        if (reset_n && m_owner >= 0)
            chk("bus_drive", {bus_wren, bus_rden, bus_addr, bus_write_val},
                {core_wren[m_owner], core_rden[m_owner],
                 core_addr[16*m_owner +: 16], core_write_val[16*m_owner +: 16]});
        else
            chk("bus_strobes", {bus_wren, bus_rden}, 2'b00);
        chk("read_val", core_read_val, m_force ? 16'hFFFF : bus_read_val);
        chk("tmo_status", {timeout_flag, timeout_core}, {m_flag, 2'(m_tcore)});
        m_rdy = erdy;
        if (reset_n) begin
            m_force = tmo;
            if (m_owner < 0) begin
                for (int d = 0; d < N; d++) begin
                    int c;
                    c = (m_last + 1 + d) % N;
                    if (m_owner < 0 && req[c]) begin
                        m_owner = c;
                        m_age   = 0;
                    end
                end
            end else if (done || tmo) begin
                if (tmo) begin
                    m_flag  = 1'b1;
                    m_tcore = m_owner;
                end
                m_last  = m_owner;
                m_owner = -1;
            end else if (!req[m_owner]) begin
                m_owner = -1;
            end else begin
                m_age++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        core_wren = '0;
        core_rden = '0;
        core_addr = '0;
        core_write_val = '0;
        bus_ready = 1'b0;
        bus_read_val = '0;
        reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    function automatic logic [15:0] vaddr(input int c);
        return 16'h4000 + 16'(c) * 16'h0111;
    endfunction

    typedef struct {
        logic [N-1:0] wren;
        logic [N-1:0] rden;
        logic         brdy;
        logic         gnt_valid;
        int           gnt_core;
        logic         exp_wren;
        logic         exp_rden;
        logic [N-1:0] exp_rdy;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int k;
        bit pend[N];
        int p_rdy;
        int unsigned rw;

        vecs[0] = '{4'b0001, 4'b0000, 1'b1, 1'b1, 0, 1'b1, 1'b0, 4'b0001};
        vecs[1] = '{4'b0110, 4'b0000, 1'b1, 1'b1, 1, 1'b1, 1'b0, 4'b0010};
        vecs[2] = '{4'b0000, 4'b1000, 1'b0, 1'b1, 3, 1'b0, 1'b1, 4'b0000};
        vecs[3] = '{4'b1010, 4'b0100, 1'b1, 1'b1, 1, 1'b1, 1'b0, 4'b0010};
        vecs[4] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 0, 1'b0, 1'b0, 4'b0000};
        vecs[5] = '{4'b0000, 4'b1100, 1'b1, 1'b1, 2, 1'b0, 1'b1, 4'b0100};
        vecs[6] = '{4'b0001, 4'b0001, 1'b0, 1'b1, 0, 1'b1, 1'b1, 4'b0000};

        // Reset state
        do_reset();
        bus_read_val = 16'h1357;
        bus_ready = 1'b1;
        #1;
        chk("rst_ready", core_ready, 4'b0000);
        chk("rst_strobes", {bus_wren, bus_rden}, 2'b00);
        chk("rst_flag", {timeout_flag, timeout_core}, 3'b000);
        chk("rst_read_val", core_read_val, 16'h1357);
        tick();

        // Vector table: first arbitration after reset (rr_ptr = 0)
        for (int v = 0; v < 7; v++) begin
            do_reset();
            for (int c = 0; c < N; c++)
                set_core(c, vecs[v].wren[c], vecs[v].rden[c], vaddr(c), 16'hD000 + 16'(c));
            bus_ready = vecs[v].brdy;
            #1;
            chk("vec_idle_ready", core_ready, 4'b0000);
            tick();
            if (vecs[v].gnt_valid) begin
                chk("vec_addr", bus_addr, vaddr(vecs[v].gnt_core));
                chk("vec_wdata", bus_write_val, 16'hD000 + 16'(vecs[v].gnt_core));
            end
            chk("vec_strobes", {bus_wren, bus_rden}, {vecs[v].exp_wren, vecs[v].exp_rden});
            chk("vec_ready", core_ready, vecs[v].exp_rdy);
            core_wren = '0;
            core_rden = '0;
            tick();
        end

        // Single access: core 2 reads 0x4010, device answers immediately
        do_reset();
        set_core(2, 1'b0, 1'b1, 16'h4010, 16'h0);
        bus_ready = 1'b1;
        #1;
        chk("single_c1_ready", core_ready, 4'b0000);
        tick();
        chk("single_c2_ready", core_ready, 4'b0100);
        chk("single_addr", bus_addr, 16'h4010);
        chk("single_rden", {bus_wren, bus_rden}, 2'b01);
        set_core(2, 1'b0, 1'b0, 16'h4010, 16'h0);
        bus_ready = 1'b0;
        bus_read_val = 16'hBEEF;
        tick();
        chk("single_read_val", core_read_val, 16'hBEEF);
        chk("single_ready_once", core_ready, 4'b0000);
        tick();

        // Simultaneous writes from cores 0 and 1
        do_reset();
        set_core(0, 1'b1, 1'b0, 16'h1000, 16'hAAAA);
        set_core(1, 1'b1, 1'b0, 16'h1001, 16'hBBBB);
        bus_ready = 1'b1;
        tick();
        chk("sim_c0_addr", {bus_addr, bus_write_val}, {16'h1000, 16'hAAAA});
        chk("sim_c0_ready", core_ready, 4'b0001);
        set_core(0, 1'b0, 1'b0, 16'h1000, 16'hAAAA);
        tick();
        chk("sim_gap_strobes", {bus_wren, bus_rden}, 2'b00);
        chk("sim_gap_ready", core_ready, 4'b0000);
        tick();
        chk("sim_c1_addr", {bus_addr, bus_write_val}, {16'h1001, 16'hBBBB});
        chk("sim_c1_ready", core_ready, 4'b0010);
        core_wren = '0;
        tick();

        // Fairness: all cores request continuously, 3-cycle device latency
        do_reset();
        for (int c = 0; c < N; c++) set_core(c, 1'b1, 1'b0, vaddr(c), 16'h0);
        k = 0;
        for (int cyc = 0; cyc < 80 && k < 8; cyc++) begin
            bus_ready = (m_owner >= 0 && m_age == 2);
            #1;
            if (bus_ready) begin
                chk("fair_order", core_ready, 4'b0001 << (k % N));
                k++;
            end
            tick();
        end
        chk("fair_count", k, 8);
        core_wren = '0;
        bus_ready = 1'b0;
        tick();

        // Timeout: core 3 reads from a device that never answers
        do_reset();
        set_core(3, 1'b0, 1'b1, 16'h7777, 16'h0);
        tick();
        for (int c = 1; c <= TMO; c++) begin
            chk("tmo_ready3", core_ready[3], (c == TMO));
            tick();
        end
        set_core(3, 1'b0, 1'b0, 16'h7777, 16'h0);
        bus_read_val = 16'h1234;
        #1;
        chk("tmo_read_val", core_read_val, 16'hFFFF);
        chk("tmo_flag", timeout_flag, 1'b1);
        chk("tmo_core", timeout_core, 2'd3);
        tick();
        chk("tmo_force_once", core_read_val, 16'h1234);
        chk("tmo_sticky", timeout_flag, 1'b1);

        // Device ack coinciding with the watchdog limit counts as normal
        do_reset();
        set_core(1, 1'b0, 1'b1, 16'h2222, 16'h0);
        tick();
        for (int c = 1; c <= TMO; c++) begin
            bus_ready = (c == TMO);
            tick();
        end
        set_core(1, 1'b0, 1'b0, 16'h2222, 16'h0);
        bus_ready = 1'b0;
        bus_read_val = 16'h5A5A;
        #1;
        chk("coinc_read_val", core_read_val, 16'h5A5A);
        chk("coinc_flag", timeout_flag, 1'b0);
        tick();

        // Reset in the middle of a grant
        do_reset();
        set_core(1, 1'b1, 1'b0, vaddr(1), 16'h0);
        bus_ready = 1'b1;
        tick();
        tick();
        set_core(0, 1'b1, 1'b0, vaddr(0), 16'h0);
        set_core(1, 1'b0, 1'b0, vaddr(1), 16'h0);
        set_core(2, 1'b1, 1'b0, vaddr(2), 16'h0);
        bus_ready = 1'b0;
        tick();
        chk("rstmid_gnt2", bus_addr, vaddr(2));
        bus_ready = 1'b1;
        #1;
        chk("rstmid_pre_ready", core_ready, 4'b0100);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("rstmid_strobes", {bus_wren, bus_rden}, 2'b00);
        chk("rstmid_ready", core_ready, 4'b0000);
        tick();
        reset_n = 1'b1;
        bus_ready = 1'b0;
        tick();
        chk("rstmid_restart_c0", {bus_wren, bus_addr}, {1'b1, vaddr(0)});
        core_wren = '0;
        tick();

        // Abandon: granted core drops its request before the device answers
        do_reset();
        set_core(1, 1'b0, 1'b1, vaddr(1), 16'h0);
        tick();
        tick();
        set_core(1, 1'b0, 1'b0, vaddr(1), 16'h0);
        #1;
        chk("abandon_ready", core_ready, 4'b0000);
        tick();
        set_core(0, 1'b1, 1'b0, vaddr(0), 16'h0);
        set_core(2, 1'b1, 1'b0, vaddr(2), 16'h0);
        bus_ready = 1'b1;
        #1;
        chk("abandon_idle_ready", core_ready, 4'b0000);
        tick();
        chk("abandon_rr_kept", bus_addr, vaddr(0));
        core_wren = '0;
        bus_ready = 1'b0;
        tick();

        // Random traffic against the reference model
        do_reset();
        for (int c = 0; c < N; c++) pend[c] = 1'b0;
        p_rdy = 4;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 250 == 0) p_rdy = (p_rdy == 35) ? 4 : 35;
            for (int c = 0; c < N; c++) begin
                if (m_rdy[c]) pend[c] = 1'b0;
                if (!pend[c]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        rw = $urandom_range(1, 3);
                        set_core(c, rw[0], rw[1], 16'($urandom), 16'($urandom));
                        pend[c] = 1'b1;
                    end else begin
                        core_wren[c] = 1'b0;
                        core_rden[c] = 1'b0;
                    end
                end
            end
            bus_ready = ($urandom_range(0, 99) < p_rdy);
            bus_read_val = 16'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
